br_resolve: RTL and testbench
=============================

# br_resolve

Branch resolution unit for the pipelined RV32I core. Sits in EX beside the branch comparator: drives the comparator's signedness select, consumes its `br_less` and `br_equal` flags, and decides each branch outcome. It also keeps a 2-bit branch history table (BHT) that supplies direction predictions to ID. On a misprediction or jump, it issues a registered one-cycle redirect and flush to the front end.

## Interface
- `BHT_DEPTH`, 64: number of 2-bit counters; power of two, 4..1024.
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_pc_id`  in  32  PC of the instruction in ID; used for the prediction lookup.
- `o_pred_taken`  out  1  prediction for `i_pc_id`; combinational read of registered BHT.
- `i_ex_valid`  in  1  EX holds a live instruction.
- `i_ex_stall`  in  1  EX is frozen this cycle.
- `i_ex_pc`  in  32  PC of the EX instruction.
- `i_ex_is_br`, `i_ex_is_jal`, `i_ex_is_jalr`  in  1 each  instruction class; at most one is high.
- `i_ex_funct3`  in  3  branch funct3.
- `i_ex_pred_taken`  in  1  ID prediction, piped down with the instruction.
- `i_ex_target`  in  32  computed branch or jump target.
- `o_br_unsigned`  out  1  comparator mode; equals `i_ex_funct3[1]`.
- `i_br_less`, `i_br_equal`  in  1 each  comparator flags for the current EX operands.
- `o_redirect`  out  1  one-cycle redirect/flush pulse. Reset value 0.
- `o_redirect_pc`  out  32  fetch address while `o_redirect` is high. Reset value 0.
- `o_br_count`, `o_mispred_count`  out  32 each  performance counters. Reset value 0.

## Operation
- **Resolve condition:**
  - resolve = `i_ex_valid && !i_ex_stall && !o_redirect`.
  - The EX instruction in the same cycle as a redirect pulse is wrong-path. It is ignored completely: no BHT update, no count, no redirect.
- **Taken decode** (`i_ex_is_br` only):
  - 000 → equal
  - 001 → !equal
  - 100 → less
  - 110 → less
  - 101 → !less
  - 111 → !less
  - 010 and 011 → not taken, no BHT update, no count.
- **Redirect rules:**
  - Branch with actual taken ≠ `i_ex_pred_taken`: redirect.
    - Redirect PC = `i_ex_target` when taken.
    - Redirect PC = `i_ex_pc + 4` when not taken (32-bit wrap).
  - JAL/JALR: redirect to `i_ex_target` unconditionally. Not counted, no BHT update.
- **BHT:**
  - Index = `pc[$clog2(BHT_DEPTH)+1:2]`.
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Prediction = counter MSB.
  - On a resolved valid branch: saturating increment if taken, decrement if not.
  - The write lands at the clock edge. A same-cycle read of the same index by ID returns the old value; there is no bypass.
- **Counters:**
  - `o_br_count` increments per resolved valid branch.
  - `o_mispred_count` increments per branch redirect.
  - Both wrap at 2^32.
- **Reset:**
  - All outputs go to 0 and every BHT entry to 01 in the cycle `i_reset` is sampled high.
  - A redirect computed in the reset cycle is discarded.

## Timing
- `o_pred_taken` and `o_br_unsigned` are combinational, with zero latency.
- Redirect latency is 1 cycle: resolution in cycle N gives `o_redirect`=1 and a valid `o_redirect_pc` in cycle N+1. `o_redirect` is 0 in N+2 unless a new event occurs.
- Back-to-back redirects are impossible: the cycle after a pulse is always masked by the `!o_redirect` term.
- A stall holding EX for k cycles produces exactly one resolution, on the first non-stalled cycle.
- The BHT update and counter increments become visible in cycle N+1.

## Configuration
- Macro: `BR_RESOLVE_BHT_EN`.
- **Defined:** the BHT is instantiated and prediction is dynamic as described above.
- **Undefined:**
  - No BHT storage; `o_pred_taken` is tied 0 (static not-taken).
  - A branch redirects exactly when it is taken.
  - Counters and JAL/JALR behaviour are unchanged.

## Test plan
- **Reset defaults:** reset, then `i_pc_id`=0x100 → `o_pred_taken`=0 with the macro both on and off; all outputs 0.
- **BEQ mispredict:** pc 0x100, equal=1, pred=0, target 0x180 → next cycle `o_redirect`=1, `o_redirect_pc`=0x180, `o_mispred_count`=1. Repeat twice → `o_pred_taken` for 0x100 becomes 1 (01→10→11).
- **BGEU mispredict:** funct3=111 → `o_br_unsigned`=1. With less=1, pred=1, pc 0xFFFFFFFC → `o_redirect_pc`=0x00000000 (wrap).
- **JAL:** JAL at 0x200 targeting 0x400 → redirect to 0x400, `o_br_count` unchanged. The EX instruction in the following cycle is a taken BNE → ignored, no second pulse.
- **Stall:** stall held 3 cycles on a mispredicted BLT → exactly one redirect, `o_br_count` incremented once. Illegal funct3 010 → no redirect, no count.
- **Counter saturation:** 4 not-taken updates at one index → counter saturates at 00. Assert reset mid-sequence with a pending redirect → `o_redirect`=0 the next cycle.

Source files
------------

// File: rtl/br_resolve.sv
// Branch resolution unit: decodes branch outcome from comparator flags, issues a registered
// one-cycle redirect, keeps perf counters and (with BR_RESOLVE_BHT_EN) a 2-bit BHT predictor.
module br_resolve #(
    parameter int BHT_DEPTH = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_id,
    output logic        o_pred_taken,
    input  logic        i_ex_valid,
    input  logic        i_ex_stall,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jal,
    input  logic        i_ex_is_jalr,
    input  logic [2:0]  i_ex_funct3,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_target,
    output logic        o_br_unsigned,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic        redirect_reg;
    logic [31:0] redirect_pc_reg;
    logic [31:0] br_count_reg;
    logic [31:0] mispred_count_reg;

    logic resolve;
    logic br_legal;
    logic br_taken;
    logic br_event;
    logic br_mispred;
    logic jump_event;
    logic pred_used;

    // The instruction sitting in EX during a redirect pulse is wrong-path and is dropped.
    assign resolve = i_ex_valid && !i_ex_stall && !redirect_reg;

    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (i_ex_funct3)
            3'b000:         br_taken = i_br_equal;
            3'b001:         br_taken = !i_br_equal;
            3'b100, 3'b110: br_taken = i_br_less;
            3'b101, 3'b111: br_taken = !i_br_less;
            default:        br_legal = 1'b0;
        endcase
    end

    assign br_event      = resolve && i_ex_is_br && br_legal;
    assign br_mispred    = br_event && (br_taken != pred_used);
    assign jump_event    = resolve && (i_ex_is_jal || i_ex_is_jalr);
    assign o_br_unsigned = i_ex_funct3[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            redirect_reg      <= 1'b0;
            redirect_pc_reg   <= 32'd0;
            br_count_reg      <= 32'd0;
            mispred_count_reg <= 32'd0;
        end else begin
            redirect_reg <= br_mispred || jump_event;
            if (br_mispred || jump_event) begin
                redirect_pc_reg <= (jump_event || br_taken) ? i_ex_target : i_ex_pc + 32'd4;
            end
            if (br_event) begin
                br_count_reg <= br_count_reg + 32'd1;
            end
            if (br_mispred) begin
                mispred_count_reg <= mispred_count_reg + 32'd1;
            end
        end
    end

    assign o_redirect      = redirect_reg;
    assign o_redirect_pc   = redirect_pc_reg;
    assign o_br_count      = br_count_reg;
    assign o_mispred_count = mispred_count_reg;

`ifdef BR_RESOLVE_BHT_EN
    logic [2*BHT_DEPTH-1:0] bht_flat;
    logic [IDX_W-1:0]       rd_idx;
    logic [IDX_W-1:0]       wr_idx;
    logic                   unused_pc_bits;

    assign rd_idx         = i_pc_id[IDX_W+1:2];
    assign wr_idx         = i_ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{i_pc_id[31:IDX_W+2], i_pc_id[1:0]};
    assign pred_used      = i_ex_pred_taken;
    // Read sees the pre-update counter; a same-cycle write is not bypassed.
    assign o_pred_taken   = bht_flat[{rd_idx, 1'b1}];

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            logic [1:0] ctr_reg;
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    ctr_reg <= 2'b01;
                end else if (br_event && (wr_idx == IDX_W'(gi))) begin
                    if (br_taken && (ctr_reg != 2'b11)) begin
                        ctr_reg <= ctr_reg + 2'd1;
                    end else if (!br_taken && (ctr_reg != 2'b00)) begin
                        ctr_reg <= ctr_reg - 2'd1;
                    end
                end
            end
            assign bht_flat[2*gi +: 2] = ctr_reg;
        end
    endgenerate
`else
    logic unused_inputs;

    assign unused_inputs = ^{i_pc_id, i_ex_pred_taken};
    // Static not-taken: every taken branch is a misprediction.
    assign pred_used     = 1'b0;
    assign o_pred_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: a driver pushes per-cycle expectations from a behavioural
// model, a negedge monitor pops and compares them against the DUT outputs.
module tb_br_resolve;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pc_id;
    logic        o_pred_taken;
    logic        i_ex_valid;
    logic        i_ex_stall;
    logic [31:0] i_ex_pc;
    logic        i_ex_is_br;
    logic        i_ex_is_jal;
    logic        i_ex_is_jalr;
    logic [2:0]  i_ex_funct3;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_target;
    logic        o_br_unsigned;
    logic        i_br_less;
    logic        i_br_equal;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_count;
    logic [31:0] o_mispred_count;

    br_resolve #(.BHT_DEPTH(64)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pc_id(i_pc_id), .o_pred_taken(o_pred_taken),
        .i_ex_valid(i_ex_valid), .i_ex_stall(i_ex_stall), .i_ex_pc(i_ex_pc),
        .i_ex_is_br(i_ex_is_br), .i_ex_is_jal(i_ex_is_jal), .i_ex_is_jalr(i_ex_is_jalr),
        .i_ex_funct3(i_ex_funct3), .i_ex_pred_taken(i_ex_pred_taken), .i_ex_target(i_ex_target),
        .o_br_unsigned(o_br_unsigned), .i_br_less(i_br_less), .i_br_equal(i_br_equal),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_br_count(o_br_count), .o_mispred_count(o_mispred_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst, valid, stall, is_br, is_jal, is_jalr;
        logic [2:0]  f3;
        logic        pred, lt, eq;
        logic [31:0] pc, tgt, pc_id;
    } stim_t;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc, brc, mpc;
        logic        pred, uns;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model state
    int          m_bht[64];
    logic        m_redirect;
    logic [31:0] m_rpc, m_brc, m_mpc;

    function automatic int bht_idx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
`ifdef BR_RESOLVE_BHT_EN
        return m_bht[bht_idx(pc)] >= 2;
`else
        return 1'b0;
`endif
    endfunction

    // Model step at a rising edge, using the inputs the DUT sampled there.
    task automatic model_edge();
        bit resolve, legal, taken, is_jump, mis;
        if (i_reset) begin
            m_redirect = 0; m_rpc = 0; m_brc = 0; m_mpc = 0;
            foreach (m_bht[k]) m_bht[k] = 1;
            return;
        end
        resolve = i_ex_valid && !i_ex_stall && !m_redirect;
        legal = 1; taken = 0;
        case (i_ex_funct3)
            3'd0: taken = i_br_equal;
            3'd1: taken = !i_br_equal;
            3'd4: taken = i_br_less;
            3'd6: taken = i_br_less;
            3'd5: taken = !i_br_less;
            3'd7: taken = !i_br_less;
            default: legal = 0;
        endcase
        is_jump = resolve && (i_ex_is_jal || i_ex_is_jalr);
        mis = 0;
        if (resolve && i_ex_is_br && legal) begin
            m_brc = m_brc + 1;
`ifdef BR_RESOLVE_BHT_EN
            mis = (taken != i_ex_pred_taken);
            if (taken) m_bht[bht_idx(i_ex_pc)] = (m_bht[bht_idx(i_ex_pc)] == 3) ? 3 : m_bht[bht_idx(i_ex_pc)] + 1;
            else       m_bht[bht_idx(i_ex_pc)] = (m_bht[bht_idx(i_ex_pc)] == 0) ? 0 : m_bht[bht_idx(i_ex_pc)] - 1;
`else
            mis = taken;
`endif
            if (mis) begin
                m_mpc = m_mpc + 1;
                m_rpc = taken ? i_ex_target : i_ex_pc + 32'd4;
            end
        end
        if (is_jump) m_rpc = i_ex_target;
        m_redirect = mis || is_jump;
    endtask

    task automatic apply(input stim_t s);
        i_reset = s.rst; i_ex_valid = s.valid; i_ex_stall = s.stall;
        i_ex_is_br = s.is_br; i_ex_is_jal = s.is_jal; i_ex_is_jalr = s.is_jalr;
        i_ex_funct3 = s.f3; i_ex_pred_taken = s.pred; i_br_less = s.lt; i_br_equal = s.eq;
        i_ex_pc = s.pc; i_ex_target = s.tgt; i_pc_id = s.pc_id;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge i_clk);
        model_edge();
        #1;
        apply(s);
        e.redirect = m_redirect; e.rpc = m_rpc; e.brc = m_brc; e.mpc = m_mpc;
        e.pred = model_pred(s.pc_id); e.uns = s.f3[1];
        q.push_back(e);
    endtask

    function automatic stim_t idle(input logic [31:0] pc_id);
        stim_t s;
        s = '{rst: 0, valid: 0, stall: 0, is_br: 0, is_jal: 0, is_jalr: 0, f3: 3'd0,
              pred: 0, lt: 0, eq: 0, pc: 32'd0, tgt: 32'd0, pc_id: pc_id};
        return s;
    endfunction

    function automatic stim_t br(input logic [31:0] pc, input logic [2:0] f3, input logic pred,
                                 input logic lt, input logic eq, input logic [31:0] tgt);
        stim_t s;
        s = idle(pc);
        s.valid = 1; s.is_br = 1; s.f3 = f3; s.pred = pred; s.lt = lt; s.eq = eq;
        s.pc = pc; s.tgt = tgt;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: one transaction per cycle, taken from the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("redirect", {31'd0, o_redirect}, {31'd0, e.redirect});
                if (e.redirect) check("redirect_pc", o_redirect_pc, e.rpc);
                check("br_count", o_br_count, e.brc);
                check("mispred_count", o_mispred_count, e.mpc);
                check("pred_taken", {31'd0, o_pred_taken}, {31'd0, e.pred});
                check("br_unsigned", {31'd0, o_br_unsigned}, {31'd0, e.uns});
                $display("t=%0t redir=%0b pc=0x%08h brc=%0d mpc=%0d pred=%0b",
                         $time, o_redirect, o_redirect_pc, o_br_count, o_mispred_count, o_pred_taken);
            end
        end
    end

    initial begin
        stim_t s;
        logic [31:0] pcs;
        m_redirect = 0; m_rpc = 0; m_brc = 0; m_mpc = 0;
        foreach (m_bht[k]) m_bht[k] = 1;
        s = idle(32'h100); s.rst = 1;
        apply(s);
        step(s);
        step(s);
        step(idle(32'h100));
        // BEQ mispredicted three times at 0x100
        for (int r = 0; r < 3; r++) begin
            step(br(32'h100, 3'b000, 1'b0, 1'b0, 1'b1, 32'h180));
            step(idle(32'h100));
            step(idle(32'h100));
        end
        // BGEU not taken with predicted taken at the top of memory: fall-through wraps
        step(br(32'hFFFF_FFFC, 3'b111, 1'b1, 1'b1, 1'b0, 32'h40));
        step(idle(32'hFFFF_FFFC));
        step(idle(32'h100));
        // JAL, followed by a wrong-path taken BNE
        s = idle(32'h200); s.valid = 1; s.is_jal = 1; s.pc = 32'h200; s.tgt = 32'h400;
        step(s);
        step(br(32'h204, 3'b001, 1'b0, 1'b0, 1'b0, 32'h500));
        step(idle(32'h200));
        step(idle(32'h200));
        // Stalled mispredicted BLT
        s = br(32'h240, 3'b100, 1'b0, 1'b1, 1'b0, 32'h280);
        s.stall = 1;
        for (int k = 0; k < 3; k++) step(s);
        s.stall = 0;
        step(s);
        step(s);
        step(idle(32'h240));
        // Illegal funct3
        step(br(32'h300, 3'b010, 1'b0, 1'b1, 1'b1, 32'h340));
        step(idle(32'h300));
        // Four not-taken updates saturate at strong not-taken
        for (int k = 0; k < 4; k++) begin
            step(br(32'h300, 3'b000, 1'b0, 1'b0, 1'b0, 32'h340));
            step(idle(32'h300));
        end
        step(br(32'h300, 3'b000, 1'b0, 1'b0, 1'b1, 32'h340));
        step(idle(32'h300));
        // Reset with a pending redirect, and a redirect computed in the reset cycle
        step(br(32'h100, 3'b000, 1'b0, 1'b0, 1'b1, 32'h180));
        s = br(32'h100, 3'b000, 1'b0, 1'b0, 1'b1, 32'h180); s.rst = 1;
        step(s);
        step(idle(32'h100));
        step(idle(32'h100));
        // Randomised traffic over a small PC window so BHT entries get reused
        for (int n = 0; n < 3000; n++) begin
            pcs = 32'h1000 + ($urandom_range(0, 79) << 2);
            s = br(pcs, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            s.valid = ($urandom_range(0, 9) != 0);
            s.stall = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 9))
                0: begin s.is_br = 0; s.is_jal = 1; end
                1: begin s.is_br = 0; s.is_jalr = 1; end
                2: s.is_br = 0;
                default: ;
            endcase
            if (n % 7 == 0) s.pc = 32'hFFFF_FFFC;
            s.rst = ($urandom_range(0, 199) == 0);
            s.pc_id = 32'h1000 + ($urandom_range(0, 79) << 2);
            step(s);
        end
        step(idle(32'h100));
        step(idle(32'h100));
        @(negedge i_clk);
        #2;
        check("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
